// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the synchronous FIFO family.
package fifo_pkg;

    // Width needed to hold an occupancy value in the range 0..depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width for indices 0..depth-1. It is at least one bit, so that DEPTH=1 corner builds still elaborate.
    function automatic int ptr_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Wrapping index counter 0..DEPTH-1 with synchronous clear, used for the FIFO read and write pointers.
module fifo_ptr_wrap #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;

    // An explicit compare against DEPTH-1 lets the pointer wrap exactly at non-power-of-two depths.
    always_comb begin
        ptr_next = ptr_reg;
        if (clr) begin
            ptr_next = '0;
        end else if (inc) begin
            ptr_next = (ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/sync_fifo_fwft.sv
// Parametrised synchronous FIFO. It supports any depth of 2 or more, and the read port works in either first-word-fall-through or registered-read mode.
module sync_fifo_fwft
    import fifo_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FWFT       = 1,
    parameter int AFULL_TH   = DEPTH - 1,
    parameter int AEMPTY_TH  = 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        flush,
    input  logic                        wr_en,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    output logic                        fifo_full,
    output logic                        fifo_afull,
    output logic                        wr_overflow,
    input  logic                        rd_en,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic                        rd_data_valid,
    output logic                        fifo_empty,
    output logic                        fifo_aempty,
    output logic                        rd_underflow,
    output logic [cnt_width(DEPTH)-1:0] fifo_count
);

    localparam int CW    = cnt_width(DEPTH);
    localparam int PTR_W = ptr_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CW-1:0]         count_reg;
    logic [CW-1:0]         count_next;
    logic                  overflow_reg;
    logic                  overflow_next;
    logic                  underflow_reg;
    logic                  underflow_next;
    logic                  rd_ok;
    logic                  wr_ok;

    assign fifo_full   = (count_reg == CW'(DEPTH));
    assign fifo_empty  = (count_reg == '0);
    assign fifo_afull  = (int'(count_reg) >= AFULL_TH);
    assign fifo_aempty = (int'(count_reg) <= AEMPTY_TH);
    assign fifo_count  = count_reg;

    // Flush wins over both ports. A push into a full FIFO is allowed when a pop is accepted in the same cycle.
    assign rd_ok = rd_en & ~fifo_empty & ~flush;
    assign wr_ok = wr_en & (~fifo_full | rd_ok) & ~flush;

    always_comb begin
        count_next     = count_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;
        if (flush) begin
            count_next     = '0;
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end else begin
            case ({wr_ok, rd_ok})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
            if (wr_en && !wr_ok)
                overflow_next = 1'b1;
            if (rd_en && fifo_empty)
                underflow_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    assign wr_overflow  = overflow_reg;
    assign rd_underflow = underflow_reg;

    // The storage array is not reset; the count and pointers alone determine which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= wr_data;
    end

    fifo_ptr_wrap #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (flush),
        .inc     (wr_ok),
        .ptr     (wr_ptr)
    );

    fifo_ptr_wrap #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (flush),
        .inc     (rd_ok),
        .ptr     (rd_ptr)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_data       = fifo_empty ? '0 : mem[rd_ptr];
            assign rd_data_valid = ~fifo_empty;
        end else begin : g_regread
            logic [DATA_WIDTH-1:0] rd_data_reg;
            logic                  rd_valid_reg;

            // rd_data keeps the last popped word. The valid signal is high for one cycle after each accepted pop.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    rd_data_reg  <= '0;
                    rd_valid_reg <= 1'b0;
                end else begin
                    rd_valid_reg <= rd_ok;
                    if (rd_ok)
                        rd_data_reg <= mem[rd_ptr];
                end
            end

            assign rd_data       = rd_data_reg;
            assign rd_data_valid = rd_valid_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed bench: a DEPTH=5 FWFT instance and a DEPTH=4 registered-read instance share one clock and one reset.
module tb_sync_fifo_fwft;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=5, FWFT=1 instance
    logic        f5 = 0, w5 = 0, r5 = 0;
    logic [31:0] wd5 = 0;
    logic        full5, afull5, ovf5, valid5, empty5, aempty5, udf5;
    logic [31:0] rd5;
    logic [2:0]  cnt5;

    // DEPTH=4, FWFT=0 instance
    logic        f4 = 0, w4 = 0, r4 = 0;
    logic [31:0] wd4 = 0;
    logic        full4, afull4, ovf4, valid4, empty4, aempty4, udf4;
    logic [31:0] rd4;
    logic [2:0]  cnt4;

    sync_fifo_fwft #(.DEPTH(5), .DATA_WIDTH(32), .FWFT(1)) dut5 (
        .clk(clk), .reset_n(reset_n), .flush(f5), .wr_en(w5), .wr_data(wd5),
        .fifo_full(full5), .fifo_afull(afull5), .wr_overflow(ovf5),
        .rd_en(r5), .rd_data(rd5), .rd_data_valid(valid5),
        .fifo_empty(empty5), .fifo_aempty(aempty5), .rd_underflow(udf5),
        .fifo_count(cnt5)
    );

    sync_fifo_fwft #(.DEPTH(4), .DATA_WIDTH(32), .FWFT(0)) dut4 (
        .clk(clk), .reset_n(reset_n), .flush(f4), .wr_en(w4), .wr_data(wd4),
        .fifo_full(full4), .fifo_afull(afull4), .wr_overflow(ovf4),
        .rd_en(r4), .rd_data(rd4), .rd_data_valid(valid4),
        .fifo_empty(empty4), .fifo_aempty(aempty4), .rd_underflow(udf4),
        .fifo_count(cnt4)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        $display("[%0t] d5 wr=%0b rd=%0b fl=%0b cnt=%0d out=0x%0h v=%0b | d4 wr=%0b rd=%0b cnt=%0d out=0x%0h v=%0b",
                 $time, w5, r5, f5, cnt5, rd5, valid5, w4, r4, cnt4, rd4, valid4);
    endtask

    task automatic idle5();
        w5 = 0; r5 = 0; f5 = 0;
    endtask

    initial begin
        logic [31:0] exp_q [$];
        logic [31:0] e;

        // Reset state
        #2;
        chk("rst_empty5", empty5, 1);
        chk("rst_aempty5", aempty5, 1);
        chk("rst_full5", full5, 0);
        chk("rst_afull5", afull5, 0);
        chk("rst_cnt5", cnt5, 0);
        chk("rst_rd5", rd5, 0);
        chk("rst_valid5", valid5, 0);
        chk("rst_ovf5", ovf5, 0);
        chk("rst_udf5", udf5, 0);
        chk("rst_rd4", rd4, 0);
        chk("rst_valid4", valid4, 0);
        chk("rst_empty4", empty4, 1);
        @(negedge clk);
        reset_n = 1;
        step();

        // Fill DEPTH=5 with 0x11..0x55, then overflow with 0x66
        for (int i = 1; i <= 5; i++) begin
            w5 = 1; wd5 = 32'(i * 'h11);
            step();
        end
        chk("fill_full", full5, 1);
        chk("fill_cnt", cnt5, 5);
        chk("fill_afull", afull5, 1);
        chk("fill_head", rd5, 32'h11);
        wd5 = 32'h66;
        step();
        chk("ovf_cnt", cnt5, 5);
        chk("ovf_flag", ovf5, 1);
        idle5();
        for (int i = 1; i <= 5; i++) begin
            chk("pop_data", rd5, 32'(i * 'h11));
            chk("pop_valid", valid5, 1);
            r5 = 1;
            step();
        end
        idle5();
        chk("drain_empty", empty5, 1);
        chk("drain_valid", valid5, 0);
        chk("drain_rd", rd5, 0);
        chk("drain_ovf_sticky", ovf5, 1);
        chk("drain_udf", udf5, 0);
        f5 = 1;
        step();
        idle5();
        chk("flush_ovf", ovf5, 0);

        // Sustained push+pop at full across the pointer wrap
        for (int i = 1; i <= 5; i++) begin
            w5 = 1; wd5 = 32'(i);
            exp_q.push_back(32'(i));
            step();
        end
        for (int i = 0; i < 12; i++) begin
            e = exp_q.pop_front();
            chk("stream_data", rd5, e);
            w5 = 1; r5 = 1; wd5 = 32'h100 + 32'(i);
            exp_q.push_back(wd5);
            step();
            chk("stream_cnt", cnt5, 5);
        end
        idle5();
        chk("stream_ovf", ovf5, 0);
        chk("stream_udf", udf5, 0);
        chk("stream_head", rd5, exp_q[0]);
        exp_q.delete();
        f5 = 1;
        step();
        idle5();

        // Push+pop on empty: push only, underflow flagged
        w5 = 1; r5 = 1; wd5 = 32'hCAFE;
        step();
        idle5();
        chk("cafe_cnt", cnt5, 1);
        chk("cafe_udf", udf5, 1);
        chk("cafe_data", rd5, 32'hCAFE);
        chk("cafe_valid", valid5, 1);

        // Reach count=3 with overflow set, then flush together with a push
        for (int i = 0; i < 5; i++) begin
            w5 = 1; wd5 = 32'h200 + 32'(i);
            step();
        end
        w5 = 0; r5 = 1;
        step();
        step();
        idle5();
        chk("pre_flush_cnt", cnt5, 3);
        chk("pre_flush_ovf", ovf5, 1);
        f5 = 1; w5 = 1; wd5 = 32'hDEAD;
        step();
        idle5();
        chk("flush_cnt", cnt5, 0);
        chk("flush_empty", empty5, 1);
        chk("flush_ovf2", ovf5, 0);
        chk("flush_udf", udf5, 0);
        chk("flush_valid", valid5, 0);
        step();
        chk("flush_discard", cnt5, 0);

        // Asynchronous reset mid-burst
        w5 = 1; wd5 = 32'hA1;
        step();
        wd5 = 32'hA2;
        step();
        chk("burst_cnt", cnt5, 2);
        reset_n = 0;
        #2;
        chk("areset_cnt", cnt5, 0);
        chk("areset_empty", empty5, 1);
        chk("areset_valid", valid5, 0);
        chk("areset_rd", rd5, 0);
        reset_n = 1;
        wd5 = 32'h77;
        step();
        idle5();
        chk("post_rst_data", rd5, 32'h77);
        chk("post_rst_cnt", cnt5, 1);

        // Registered-read mode, DEPTH=4
        w4 = 1; wd4 = 32'hA0;
        step();
        wd4 = 32'hB0;
        step();
        w4 = 0;
        chk("rr_cnt", cnt4, 2);
        chk("rr_aempty", aempty4, 0);
        chk("rr_afull", afull4, 0);
        chk("rr_idle_valid", valid4, 0);
        r4 = 1;
        step();
        r4 = 0;
        chk("rr_data_a", rd4, 32'hA0);
        chk("rr_valid_a", valid4, 1);
        step();
        chk("rr_pulse_a", valid4, 0);
        chk("rr_hold_a", rd4, 32'hA0);
        r4 = 1;
        step();
        r4 = 0;
        chk("rr_data_b", rd4, 32'hB0);
        chk("rr_valid_b", valid4, 1);
        step();
        chk("rr_pulse_b", valid4, 0);
        chk("rr_hold_b", rd4, 32'hB0);
        chk("rr_empty", empty4, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
